// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer slice.
package ser_pkg;

   localparam int WORD_W         = 64;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CSUM = 2'd2
   } state_t;

   // XOR of all bytes of a word; used as the optional trailing checksum byte.
   function automatic logic [BYTE_W-1:0] word_xor(input logic [WORD_W-1:0] word);
      logic [BYTE_W-1:0] acc;
      acc = {BYTE_W{1'b0}};
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         acc = acc ^ word[i*BYTE_W +: BYTE_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out handshake bundle; master is the serializer, slave is its environment.
interface byte_serializer_if #(
   parameter int FIFO_DEPTH = 4
);
   import ser_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [WORD_W-1:0] d_in;
   logic              d_in_valid;
   logic              d_in_ready;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_ready;
   logic              byte_start;
   logic              byte_last;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      input  d_in, d_in_valid, byte_ready,
      output d_in_ready, byte_out, byte_valid, byte_start, byte_last, fifo_count
   );

   modport slave (
      output d_in, d_in_valid, byte_ready,
      input  d_in_ready, byte_out, byte_valid, byte_start, byte_last, fifo_count
   );

endinterface

// File: rtl/byte_serializer_word_fifo.sv
// Synchronous word FIFO; writes are refused when full and pops when empty, so count never saturates.
module word_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;

   assign full_s  = (count_r == CNT_W'(DEPTH));
   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign push_s  = wr_en & ~full_s;
   assign pop_s   = rd_en & ~empty_s;

   assign rd_data = mem_r[rd_ptr_r];
   assign full    = full_s;
   assign empty   = empty_s;
   assign count   = count_r;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/byte_serializer.sv
// Buffers 64-bit words and emits them MSB-first as a framed byte stream.
// Defining SER_CHECKSUM_EN appends a ninth XOR checksum byte to every frame.
module byte_serializer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int BYTES_PER_WORD = 8
) (
   input  logic                clk,
   input  logic                reset,
   byte_serializer_if.master   bus
);
   import ser_pkg::*;

   localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);

   state_t            state_r, state_s;
   logic [WORD_W-1:0] shift_r, shift_s;
   logic [2:0]        byte_idx_r, byte_idx_s;
   logic              byte_valid_r, byte_valid_s;
   logic              byte_start_r, byte_start_s;
   logic              byte_last_r, byte_last_s;
`ifdef SER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_r, csum_s;
`endif

   logic              hs_s;
   logic              word_done_s;
   logic              pop_s;
   logic              push_s;
   logic              d_in_ready_s;
   logic [WORD_W-1:0] fifo_rdata_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;

   assign d_in_ready_s = ~fifo_full_s & ~reset;
   assign push_s       = bus.d_in_valid & d_in_ready_s;
   assign hs_s         = byte_valid_r & bus.byte_ready;

   word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_word_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_s),
      .wr_data (bus.d_in),
      .rd_en   (pop_s),
      .rd_data (fifo_rdata_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   // Next-state logic; a finished frame (or idle) pulls the next word in the same edge.
   always_comb begin
      state_s      = state_r;
      shift_s      = shift_r;
      byte_idx_s   = byte_idx_r;
      byte_valid_s = byte_valid_r;
      byte_start_s = byte_start_r;
      byte_last_s  = byte_last_r;
      word_done_s  = 1'b0;
      pop_s        = 1'b0;
`ifdef SER_CHECKSUM_EN
      csum_s       = csum_r;
`endif
      case (state_r)
         IDLE: word_done_s = 1'b1;
         SEND: begin
            if (hs_s && (byte_idx_r == LAST_IDX)) begin
`ifdef SER_CHECKSUM_EN
               state_s      = CSUM;
               shift_s      = {csum_r, {(WORD_W-BYTE_W){1'b0}}};
               byte_start_s = 1'b0;
               byte_last_s  = 1'b1;
`else
               word_done_s  = 1'b1;
`endif
            end else if (hs_s) begin
               shift_s      = {shift_r[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
               byte_idx_s   = byte_idx_r + 3'd1;
               byte_start_s = 1'b0;
`ifdef SER_CHECKSUM_EN
               byte_last_s  = 1'b0;
`else
               byte_last_s  = (byte_idx_r == (LAST_IDX - 3'd1));
`endif
            end else begin
               byte_valid_s = 1'b1;
            end
         end
`ifdef SER_CHECKSUM_EN
         CSUM: begin
            if (hs_s) begin
               word_done_s  = 1'b1;
            end else begin
               byte_valid_s = 1'b1;
            end
         end
`endif
         default: word_done_s = 1'b1;
      endcase

      if (word_done_s) begin
         if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            state_s      = SEND;
            shift_s      = fifo_rdata_s;
            byte_idx_s   = 3'd0;
            byte_valid_s = 1'b1;
            byte_start_s = 1'b1;
            byte_last_s  = 1'b0;
`ifdef SER_CHECKSUM_EN
            csum_s       = word_xor(fifo_rdata_s);
`endif
         end else begin
            state_s      = IDLE;
            shift_s      = {WORD_W{1'b0}};
            byte_idx_s   = 3'd0;
            byte_valid_s = 1'b0;
            byte_start_s = 1'b0;
            byte_last_s  = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         shift_r      <= {WORD_W{1'b0}};
         byte_idx_r   <= 3'd0;
         byte_valid_r <= 1'b0;
         byte_start_r <= 1'b0;
         byte_last_r  <= 1'b0;
`ifdef SER_CHECKSUM_EN
         csum_r       <= {BYTE_W{1'b0}};
`endif
      end else begin
         state_r      <= state_s;
         shift_r      <= shift_s;
         byte_idx_r   <= byte_idx_s;
         byte_valid_r <= byte_valid_s;
         byte_start_r <= byte_start_s;
         byte_last_r  <= byte_last_s;
`ifdef SER_CHECKSUM_EN
         csum_r       <= csum_s;
`endif
      end
   end

   assign bus.d_in_ready = d_in_ready_s;
   assign bus.byte_out   = shift_r[WORD_W-1 -: BYTE_W];
   assign bus.byte_valid = byte_valid_r;
   assign bus.byte_start = byte_start_r;
   assign bus.byte_last  = byte_last_r;
   assign bus.fifo_count = fifo_count_s;

endmodule
